instruction_fetch_unit: RTL and testbench

Sequencer that drives the instruction memory address bus and consumes the fetched 8-bit word, one instruction at a time. Holds the 4-bit program counter, resolves JMP/HALT/NOP locally, and hands every other instruction to the execute stage over a valid/ready handshake. Sits between `instruction_memory` (synchronous read, one-cycle latency) and the decode/execute logic of the 4-bit CPU.

---
 rtl/instruction_fetch_unit.sv | 124 ++++++++++++
 tb/tb_instruction_fetch_unit.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch sequencer for the 4-bit CPU: drives the instruction memory address,
// resolves NOP/JMP/HALT locally and issues all other instructions over valid/ready.
module instruction_fetch_unit #(
  parameter int unsigned PC_W     = 4,
  parameter int unsigned INSTR_W  = 8,
  parameter logic [3:0]  OPC_NOP  = 4'b0000,
  parameter logic [3:0]  OPC_JMP  = 4'b1000,
  parameter logic [3:0]  OPC_HALT = 4'b1111
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [PC_W-1:0]    pc_addr,
  input  logic [INSTR_W-1:0] instruction_in,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               busy,
  output logic               halted
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StIssue,
    StHalt
  } state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               halted_q, halted_d;

  logic [3:0]         opcode;
  logic [PC_W-1:0]    operand;
  logic [PC_W-1:0]    pc_inc;

  assign opcode  = instruction_in[INSTR_W-1 -: 4];
  assign operand = instruction_in[PC_W-1:0];
  // Natural wrap at 2^PC_W; there is no end-of-memory detection.
  assign pc_inc  = pc_q + {{(PC_W-1){1'b0}}, 1'b1};

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    halted_d = halted_q;
    unique case (state_q)
      StIdle, StHalt: begin
        if (start) begin
          pc_d     = '0;
          busy_d   = 1'b1;
          halted_d = 1'b0;
          state_d  = StFetch;
        end
      end
      StFetch: begin
        state_d = StDecode;
      end
      StDecode: begin
        case (opcode)
          OPC_HALT: begin
            busy_d   = 1'b0;
            halted_d = 1'b1;
            state_d  = StHalt;
          end
          OPC_JMP: begin
            pc_d    = operand;
            state_d = StFetch;
          end
          OPC_NOP: begin
            pc_d    = pc_inc;
            state_d = StFetch;
          end
          default: begin
            instr_d = instruction_in;
            pc_d    = pc_inc;
            valid_d = 1'b1;
            state_d = StIssue;
          end
        endcase
      end
      StIssue: begin
        if (instr_ready) begin
          valid_d = 1'b0;
          state_d = StFetch;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      pc_q     <= '0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
    end
  end

  assign pc_addr     = pc_q;
  assign instr_out   = instr_q;
  assign instr_valid = valid_q;
  assign busy        = busy_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench: synchronous-read memory model plus an instruction-level interpreter
// that predicts issued words, handshake cycles, halt cycle and final PC.
module tb_instruction_fetch_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] pc_addr;
  logic [7:0] instruction_in;
  logic [7:0] instr_out;
  logic       instr_valid;
  logic       instr_ready;
  logic       busy;
  logic       halted;

  logic [7:0] mem [16];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [7:0] exp_v [$];
  int         exp_t [$];
  bit         exp_halt;
  int         exp_halt_t;
  int         exp_pc;

  logic [7:0] obs_v [$];
  int         obs_t [$];
  int         halt_t;

  instruction_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .pc_addr        (pc_addr),
    .instruction_in (instruction_in),
    .instr_out      (instr_out),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .busy           (busy),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  // One-cycle-latency synchronous-read instruction memory.
  always @(posedge clk) instruction_in <= mem[pc_addr];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_pc"}, {28'd0, pc_addr}, 0);
    chk({tag, "_out"}, {24'd0, instr_out}, 0);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_halted"}, {31'd0, halted}, 0);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    tick();
  endtask

  // Instruction-level interpreter: NOP/JMP cost 2 cycles, issued words 3 (ready held high),
  // HALT is visible 2 cycles after the fetch that reaches it.
  task automatic model(input int max_issue, input bit patch);
    logic [7:0] m [16];
    logic [7:0] w;
    int pc;
    int t;
    m = mem;
    pc = 0;
    t = 0;
    exp_v.delete();
    exp_t.delete();
    exp_halt = 1'b0;
    exp_halt_t = 0;
    for (int s = 0; s < 300; s++) begin
      w = m[pc];
      if (w[7:4] == 4'hF) begin
        exp_halt = 1'b1;
        exp_halt_t = t + 2;
        break;
      end else if (w[7:4] == 4'h8) begin
        pc = int'(w[3:0]);
        t += 2;
      end else if (w[7:4] == 4'h0) begin
        pc = (pc + 1) % 16;
        t += 2;
      end else begin
        t += 3;
        exp_v.push_back(w);
        exp_t.push_back(t);
        pc = (pc + 1) % 16;
        if (patch && exp_v.size() == 1) m[0] = 8'hF0;
        if (exp_v.size() == max_issue) break;
      end
    end
    exp_pc = pc;
  endtask

  // mode 0: ready always high; 1: random ready; 2: first issue stalled for 4 cycles.
  task automatic run(input int mode, input int max_issue, input int cap, input bit patch,
                     input string tag);
    int         t0;
    int         stall;
    bit         hold;
    bit         patched;
    logic [7:0] held;
    logic [3:0] held_pc;
    model(max_issue, patch);
    obs_v.delete();
    obs_t.delete();
    halt_t = -1;
    stall = 0;
    hold = 1'b0;
    patched = 1'b0;
    held = '0;
    held_pc = '0;
    start = 1'b1;
    tick();
    t0 = cyc;
    start = 1'b0;
    chk({tag, "_start_busy"}, {31'd0, busy}, 1);
    chk({tag, "_start_pc"}, {28'd0, pc_addr}, 0);
    chk({tag, "_start_halted"}, {31'd0, halted}, 0);
    while (1) begin
      if (halted) begin
        halt_t = cyc - t0;
        break;
      end
      if (cyc - t0 > cap) break;
      if (mode == 0) begin
        instr_ready = 1'b1;
      end else if (mode == 1) begin
        instr_ready = ($urandom_range(0, 9) < 7);
      end else if (instr_valid && stall < 4) begin
        instr_ready = 1'b0;
        stall++;
        chk({tag, "_stall_pc"}, {28'd0, pc_addr}, 1);
      end else begin
        instr_ready = 1'b1;
      end
      if (hold) begin
        chk({tag, "_hold_valid"}, {31'd0, instr_valid}, 1);
        chk({tag, "_hold_out"}, {24'd0, instr_out}, {24'd0, held});
        chk({tag, "_hold_pc"}, {28'd0, pc_addr}, {28'd0, held_pc});
      end
      hold = instr_valid && !instr_ready;
      held = instr_out;
      held_pc = pc_addr;
      if (instr_valid && instr_ready) begin
        obs_v.push_back(instr_out);
        obs_t.push_back(cyc + 1 - t0);
        if (patch && !patched) begin
          mem[0] = 8'hF0;
          patched = 1'b1;
        end
      end
      tick();
      if (obs_v.size() == max_issue) break;
    end
    instr_ready = 1'b0;
    chk({tag, "_count"}, obs_v.size(), exp_v.size());
    for (int i = 0; i < obs_v.size() && i < exp_v.size(); i++) begin
      chk($sformatf("%s_word%0d", tag, i), {24'd0, obs_v[i]}, {24'd0, exp_v[i]});
      if (mode == 0) chk($sformatf("%s_cycle%0d", tag, i), obs_t[i], exp_t[i]);
    end
    chk({tag, "_halted"}, {31'd0, (halt_t >= 0)}, {31'd0, exp_halt});
    if (exp_halt && halt_t >= 0) begin
      chk({tag, "_halt_pc"}, {28'd0, pc_addr}, exp_pc);
      chk({tag, "_halt_busy"}, {31'd0, busy}, 0);
      chk({tag, "_halt_valid"}, {31'd0, instr_valid}, 0);
      if (mode == 0) chk({tag, "_halt_cycle"}, halt_t, exp_halt_t);
    end
  endtask

  task automatic load_b();
    foreach (mem[i]) mem[i] = 8'h00;
    mem[0] = 8'h52;
    mem[1] = 8'h00;
    mem[2] = 8'h37;
    mem[3] = 8'hF0;
  endtask

  initial begin
    bit         seen;
    logic [3:0] op;
    int         r;
    rst = 1'b1;
    start = 1'b0;
    instr_ready = 1'b0;
    foreach (mem[i]) mem[i] = 8'h00;
    repeat (2) tick();
    chk_idle("reset");
    #2 rst = 1'b0;
    repeat (3) tick();
    chk_idle("idle");
    #3 rst = 1'b1;
    #1 chk_idle("mid_rst");
    #1 rst = 1'b0;
    tick();
    chk_idle("idle2");

    // JMP back to address 1 loops on 0x57 forever.
    mem[0] = 8'h52;
    mem[1] = 8'h57;
    mem[2] = 8'h81;
    mem[3] = 8'hF0;
    run(0, 5, 200, 1'b0, "loop");
    do_reset();

    load_b();
    run(0, 8, 200, 1'b0, "halt");
    run(0, 8, 200, 1'b0, "rerun");
    run(2, 8, 200, 1'b0, "bp");

    // JMP to 15, issue there, wrap to 0 which is patched to HALT after the first issue.
    foreach (mem[i]) mem[i] = 8'h00;
    mem[0] = 8'h8F;
    mem[15] = 8'h2A;
    run(0, 8, 200, 1'b1, "wrap");

    // Reset while an instruction is being offered and not accepted.
    load_b();
    start = 1'b1;
    tick();
    start = 1'b0;
    instr_ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (instr_valid) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    chk("midissue_valid_seen", {31'd0, seen}, 1);
    #3 rst = 1'b1;
    #1 chk_idle("midissue_rst");
    #2 rst = 1'b0;
    tick();
    chk_idle("midissue_after");
    run(0, 8, 200, 1'b0, "post_rst");

    for (int k = 0; k < 12; k++) begin
      foreach (mem[i]) begin
        r = $urandom_range(0, 9);
        if (r < 2) op = 4'h0;
        else if (r == 2) op = 4'h8;
        else if (r == 3) op = 4'hF;
        else begin
          op = 4'($urandom_range(1, 14));
          if (op == 4'h8) op = 4'h9;
        end
        mem[i] = {op, 4'($urandom_range(0, 15))};
      end
      do_reset();
      run(1, 8, 2000, 1'b0, $sformatf("rnd%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
